// File: rtl/pulse_gen.sv
// pulse_gen: request-driven level/pulse generator.
// A request either sets sig to a level (rise/fall) or emits a pulse of
// programmable width. Every driven transition is followed by a guard period
// of HOLD_CYCLES cycles before the block reports completion with done.
module pulse_gen #(
    parameter logic IDLE_LEVEL  = 1'b0,
    parameter int   HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [7:0]  len,
    output logic        sig,
    output logic        busy,
    output logic        done,
    output logic [15:0] edge_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GUARD,
        S_NOEDGE
    } state_t;

    // Guard counter counts down to zero, so it is loaded with HOLD_CYCLES-1;
    // the first guard cycle is the one in which the final transition shows.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_nxt;
    logic        sig_nxt;
    logic        done_nxt;
    logic        act_lvl_q, act_lvl_nxt;   // active level of the pulse in flight
    logic        pre_q, pre_nxt;           // one-cycle pre-drop before ACTIVE
    logic [7:0]  width_q, width_nxt;       // remaining active cycles minus one
    logic [7:0]  hold_q, hold_nxt;         // remaining guard cycles minus one
    logic [7:0]  width_load;

    // len of zero behaves as one cycle; store max(len,1)-1 for a count-down.
    assign width_load = (len == 8'd0) ? 8'd0 : len - 8'd1;

    // busy reflects any non-idle state; done is a registered strobe.
    assign busy = (state_q != S_IDLE);

    // Next-state and next-output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt   = state_q;
        sig_nxt     = sig;
        done_nxt    = 1'b0;
        act_lvl_nxt = act_lvl_q;
        pre_nxt     = pre_q;
        width_nxt   = width_q;
        hold_nxt    = hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!mode[1]) begin
                        // Level request: 00 targets high, 01 targets low.
                        if (sig != ~mode[0]) begin
                            sig_nxt   = ~mode[0];
                            hold_nxt  = HOLD_LOAD;
                            state_nxt = S_GUARD;
                        end else begin
                            state_nxt = S_NOEDGE;
                        end
                    end else begin
                        // Pulse request: 10 pulses high, 11 pulses low.
                        act_lvl_nxt = ~mode[0];
                        width_nxt   = width_load;
                        state_nxt   = S_ACTIVE;
                        if (sig == ~mode[0]) begin
                            // Already at the active level: drop first so the
                            // pulse still has a visible leading edge.
                            sig_nxt = mode[0];
                            pre_nxt = 1'b1;
                        end else begin
                            sig_nxt = ~mode[0];
                            pre_nxt = 1'b0;
                        end
                    end
                end
            end

            S_ACTIVE: begin
                if (pre_q) begin
                    sig_nxt = act_lvl_q;
                    pre_nxt = 1'b0;
                end else if (width_q == 8'd0) begin
                    sig_nxt   = ~act_lvl_q;
                    hold_nxt  = HOLD_LOAD;
                    state_nxt = S_GUARD;
                end else begin
                    width_nxt = width_q - 8'd1;
                end
            end

            S_GUARD: begin
                if (hold_q == 8'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    hold_nxt = hold_q - 8'd1;
                end
            end

            S_NOEDGE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, output and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q   <= S_IDLE;
            sig       <= IDLE_LEVEL;
            done      <= 1'b0;
            edge_cnt  <= 16'd0;
            act_lvl_q <= 1'b0;
            pre_q     <= 1'b0;
            width_q   <= 8'd0;
            hold_q    <= 8'd0;
        end else begin
            state_q   <= state_nxt;
            sig       <= sig_nxt;
            done      <= done_nxt;
            act_lvl_q <= act_lvl_nxt;
            pre_q     <= pre_nxt;
            width_q   <= width_nxt;
            hold_q    <= hold_nxt;
            if (sig_nxt != sig) begin
                edge_cnt <= edge_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: scoreboard bench for pulse_gen.
// The driver computes each request's expected sig waveform from the request
// rules and queues it; a monitor collects the waveform while busy is high
// and compares it when done appears.
module tb_pulse_gen;

    localparam int HOLD = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  len;
    logic        sig;
    logic        busy;
    logic        done;
    logic [15:0] edge_cnt;

    pulse_gen #(
        .IDLE_LEVEL (1'b0),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .len     (len),
        .sig     (sig),
        .busy    (busy),
        .done    (done),
        .edge_cnt(edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           busy_len;
        logic [511:0] trace;
        logic         final_sig;
        logic [15:0]  edge_total;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic        m_sig;          // model's view of sig between requests
    logic [15:0] m_edges;        // model's running transition count

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Two-flop edge detector on sig, counting rising and falling flags.
    logic s1, s2;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    always @(posedge clk) begin
        s1 <= sig;
        s2 <= s1;
    end
    always @(negedge clk) begin
        if (s1 === 1'b1 && s2 === 1'b0) rise_cnt++;
        if (s1 === 1'b0 && s2 === 1'b1) fall_cnt++;
    end

    // Monitor: record sig while busy, compare against the queue on done.
    int           mon_cnt = 0;
    logic [511:0] mon_trace = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (mon_cnt < 512) mon_trace[mon_cnt] = sig;
                mon_cnt++;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("busy_len", mon_cnt, e.busy_len);
                    check("sig_trace", mon_trace, e.trace);
                    check("final_sig", sig, e.final_sig);
                    check("edge_cnt", edge_cnt, e.edge_total);
                    check("done_busy", busy, 0);
                end
                mon_cnt   = 0;
                mon_trace = '0;
            end
        end
    end

    // Issue one request in the current cycle and ride it out to the done
    // cycle. The expected waveform comes straight from the request rules.
    task automatic do_req(input logic [1:0] m, input logic [7:0] l, input logic hold_start);
        exp_t e;
        int   n = 0;
        int   w;
        logic tgt;
        logic [15:0] edges = 16'd0;
        e.trace = '0;
        start = 1'b1;
        mode  = m;
        len   = l;
        tgt   = (m == 2'd0 || m == 2'd2);
        if (m < 2'd2) begin
            if (m_sig != tgt) begin
                for (int i = 0; i < HOLD; i++) begin e.trace[n] = tgt; n++; end
                edges = 16'd1;
            end else begin
                e.trace[n] = m_sig; n++;
            end
        end else begin
            w = (l == 8'd0) ? 1 : int'(l);
            if (m_sig == tgt) begin
                e.trace[n] = !tgt; n++;
                edges = 16'd3;
            end else begin
                edges = 16'd2;
            end
            for (int i = 0; i < w; i++) begin e.trace[n] = tgt; n++; end
            for (int i = 0; i < HOLD; i++) begin e.trace[n] = !tgt; n++; end
        end
        m_sig        = e.trace[n-1];
        m_edges      = m_edges + edges;
        e.busy_len   = n;
        e.final_sig  = m_sig;
        e.edge_total = m_edges;
        sb_q.push_back(e);
        // Busy cycles: extra starts must be ignored.
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = hold_start ? 1'b1 : ($urandom_range(0, 2) == 0);
            mode  = 2'($urandom_range(0, 3));
            len   = 8'($urandom_range(0, 255));
        end
        // Done cycle: a new request may be issued here by the caller.
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int r0, f0, dn;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        len   = 8'd0;
        m_sig   = 1'b0;
        m_edges = 16'd0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sig", sig, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_edge_cnt", edge_cnt, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // High pulse of 3 from reset.
        do_req(2'd2, 8'd3, 1'b0);
        idle(1);
        // Rise, then a redundant rise that makes no edge.
        do_req(2'd0, 8'd0, 1'b0);
        do_req(2'd0, 8'd0, 1'b0);
        // sig is high: a len=0 high pulse drops first.
        do_req(2'd2, 8'd0, 1'b0);
        idle(2);
        // start held through a len=5 pulse, next request at done cycle.
        do_req(2'd2, 8'd5, 1'b1);
        do_req(2'd3, 8'd2, 1'b0);
        do_req(2'd3, 8'd0, 1'b0);
        do_req(2'd1, 8'd0, 1'b0);
        idle(1);

        // Width sweep with the edge detector: one rise and one fall each.
        for (int l = 0; l < 256; l++) begin
            r0 = rise_cnt;
            f0 = fall_cnt;
            do_req(2'd2, 8'(l), 1'b0);
            idle(3);
            check($sformatf("rise_flags_len%0d", l), rise_cnt - r0, 1);
            check($sformatf("fall_flags_len%0d", l), fall_cnt - f0, 1);
        end

        // Randomised requests.
        for (int k = 0; k < 200; k++) begin
            logic [7:0] rl;
            rl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 12));
            do_req(2'($urandom_range(0, 3)), rl, ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end
        idle(5);
        check("sb_drain", sb_q.size(), 0);

        // Reset in the middle of a len=10 high pulse.
        mon_en = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        start = 1'b1; mode = 2'd2; len = 8'd10;   // T0
        @(posedge clk); #1;                        // T1
        start = 1'b0;
        @(negedge clk);
        check("abort_t1_sig", sig, 1);
        check("abort_t1_busy", busy, 1);
        @(posedge clk); #1;                        // T2
        rst = 1'b1;
        @(negedge clk);
        check("abort_t2_sig", sig, 1);
        @(posedge clk); #1;                        // T3
        rst = 1'b0;
        @(negedge clk);
        check("abort_t3_sig", sig, 0);
        check("abort_t3_busy", busy, 0);
        check("abort_t3_done", done, 0);
        check("abort_t3_edge_cnt", edge_cnt, 0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
